// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator with EQ/NE/LT/LE/GT/GE/MIN/MAX modes.
// Uses a sign-magnitude compare (no subtractor) and one valid/ready handshake shared by all lanes.
module fp_cmp_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned LANES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_a,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_b,
  input  logic [2:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_flag,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_sel,
  output logic [LANES-1:0]          out_unord
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    MODE_EQ  = 3'd0,
    MODE_NE  = 3'd1,
    MODE_LT  = 3'd2,
    MODE_LE  = 3'd3,
    MODE_GT  = 3'd4,
    MODE_GE  = 3'd5,
    MODE_MIN = 3'd6,
    MODE_MAX = 3'd7
  } mode_e;

  function automatic logic is_nan(input logic [W-1:0] v);
    return (&v[W-2:MAN_W]) & (|v[MAN_W-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] v);
    return ~(|v[W-2:0]);
  endfunction

  logic advance;

  logic               s1_valid_q, s1_valid_d;
  mode_e              s1_mode_q, s1_mode_d;
  logic [LANES*W-1:0] s1_a_q, s1_a_d;
  logic [LANES*W-1:0] s1_b_q, s1_b_d;
  logic [LANES-1:0]   s1_a_nan_q, s1_a_nan_d;
  logic [LANES-1:0]   s1_b_nan_q, s1_b_nan_d;
  logic [LANES-1:0]   s1_a_zero_q, s1_a_zero_d;
  logic [LANES-1:0]   s1_b_zero_q, s1_b_zero_d;
  logic [LANES-1:0]   s1_sign_a_q, s1_sign_a_d;
  logic [LANES-1:0]   s1_sign_b_q, s1_sign_b_d;
  logic [LANES-1:0]   s1_mag_eq_q, s1_mag_eq_d;
  logic [LANES-1:0]   s1_mag_lt_q, s1_mag_lt_d;

  logic [LANES-1:0]   lane_unord, lane_eq, lane_lt, lane_gt;
  logic [LANES-1:0]   lane_min_a, lane_max_a;

  logic               out_valid_q, out_valid_d;
  logic [LANES-1:0]   out_flag_q, out_flag_d;
  logic [LANES*W-1:0] out_sel_q, out_sel_d;
  logic [LANES-1:0]   out_unord_q, out_unord_d;

  // The stall is global, so every stage moves together whenever the output slot can drain.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_a_nan_d  = s1_a_nan_q;
    s1_b_nan_d  = s1_b_nan_q;
    s1_a_zero_d = s1_a_zero_q;
    s1_b_zero_d = s1_b_zero_q;
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    s1_mag_eq_d = s1_mag_eq_q;
    s1_mag_lt_d = s1_mag_lt_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_mode_d  = mode_e'(in_mode);
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      for (int i = 0; i < int'(LANES); i++) begin
        s1_a_nan_d[i]  = is_nan(in_a[i*W +: W]);
        s1_b_nan_d[i]  = is_nan(in_b[i*W +: W]);
        s1_a_zero_d[i] = is_zero(in_a[i*W +: W]);
        s1_b_zero_d[i] = is_zero(in_b[i*W +: W]);
        s1_sign_a_d[i] = in_a[i*W + W - 1];
        s1_sign_b_d[i] = in_b[i*W + W - 1];
        s1_mag_eq_d[i] = in_a[i*W +: W-1] == in_b[i*W +: W-1];
        s1_mag_lt_d[i] = in_a[i*W +: W-1] <  in_b[i*W +: W-1];
      end
    end
  end

  // Ordered relation per lane; +0 and -0 compare equal, and for two negatives the larger magnitude is less.
  always_comb begin
    lane_unord = '0;
    lane_eq    = '0;
    lane_lt    = '0;
    lane_gt    = '0;
    lane_min_a = '0;
    lane_max_a = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_unord[i] = s1_a_nan_q[i] | s1_b_nan_q[i];
      if (s1_a_zero_q[i] & s1_b_zero_q[i]) begin
        lane_eq[i]    = 1'b1;
        lane_lt[i]    = 1'b0;
        lane_min_a[i] = s1_sign_a_q[i] | ~s1_sign_b_q[i];
        lane_max_a[i] = ~s1_sign_a_q[i] | s1_sign_b_q[i];
      end else begin
        lane_eq[i] = (s1_sign_a_q[i] == s1_sign_b_q[i]) & s1_mag_eq_q[i];
        if (s1_sign_a_q[i] != s1_sign_b_q[i]) begin
          lane_lt[i] = s1_sign_a_q[i];
        end else if (!s1_sign_a_q[i]) begin
          lane_lt[i] = s1_mag_lt_q[i];
        end else begin
          lane_lt[i] = ~s1_mag_lt_q[i] & ~s1_mag_eq_q[i];
        end
        lane_min_a[i] = lane_lt[i] | lane_eq[i];
        lane_max_a[i] = ~lane_lt[i];
      end
      lane_gt[i] = ~lane_lt[i] & ~lane_eq[i];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_flag_d  = out_flag_q;
    out_sel_d   = out_sel_q;
    out_unord_d = out_unord_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      out_flag_d  = '0;
      out_sel_d   = '0;
      out_unord_d = '0;
      if (s1_valid_q) begin
        for (int i = 0; i < int'(LANES); i++) begin
          out_unord_d[i] = lane_unord[i];
          unique case (s1_mode_q)
            MODE_EQ: out_flag_d[i] = lane_eq[i] & ~lane_unord[i];
            MODE_NE: out_flag_d[i] = ~lane_eq[i] | lane_unord[i];
            MODE_LT: out_flag_d[i] = lane_lt[i] & ~lane_unord[i];
            MODE_LE: out_flag_d[i] = (lane_lt[i] | lane_eq[i]) & ~lane_unord[i];
            MODE_GT: out_flag_d[i] = lane_gt[i] & ~lane_unord[i];
            MODE_GE: out_flag_d[i] = (lane_gt[i] | lane_eq[i]) & ~lane_unord[i];
            MODE_MIN, MODE_MAX: begin
              // A single NaN yields the other operand; only a double NaN produces the canonical qNaN.
              if (s1_a_nan_q[i] & s1_b_nan_q[i]) begin
                out_flag_d[i]       = 1'b0;
                out_sel_d[i*W +: W] = QNAN;
              end else if (s1_a_nan_q[i]) begin
                out_flag_d[i]       = 1'b0;
                out_sel_d[i*W +: W] = s1_b_q[i*W +: W];
              end else if (s1_b_nan_q[i]) begin
                out_flag_d[i]       = 1'b1;
                out_sel_d[i*W +: W] = s1_a_q[i*W +: W];
              end else begin
                out_flag_d[i]       = (s1_mode_q == MODE_MIN) ? lane_min_a[i] : lane_max_a[i];
                out_sel_d[i*W +: W] = out_flag_d[i] ? s1_a_q[i*W +: W] : s1_b_q[i*W +: W];
              end
            end
            default: out_flag_d[i] = 1'b0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_flag_q  <= '0;
      out_sel_q   <= '0;
      out_unord_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
      out_sel_q   <= out_sel_d;
      out_unord_q <= out_unord_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_mode_q   <= s1_mode_d;
    s1_a_q      <= s1_a_d;
    s1_b_q      <= s1_b_d;
    s1_a_nan_q  <= s1_a_nan_d;
    s1_b_nan_q  <= s1_b_nan_d;
    s1_a_zero_q <= s1_a_zero_d;
    s1_b_zero_q <= s1_b_zero_d;
    s1_sign_a_q <= s1_sign_a_d;
    s1_sign_b_q <= s1_sign_b_d;
    s1_mag_eq_q <= s1_mag_eq_d;
    s1_mag_lt_q <= s1_mag_lt_d;
  end

  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;
  assign out_sel   = out_sel_q;
  assign out_unord = out_unord_q;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Directed self-checking bench for fp_cmp_pipe (FP32, two lanes).
// Covers reset state, ordered and unordered compares, MIN/MAX selection, backpressure and mid-stream reset.
module tb_fp_cmp_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int LANES = 2;
  localparam int W     = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic [2:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_flag;
  logic [LANES*W-1:0] out_sel;
  logic [LANES-1:0]   out_unord;

  int testCount = 0;
  int failCount = 0;

  logic [LANES-1:0]   gotFlag;
  logic [LANES*W-1:0] gotSel;
  logic [LANES-1:0]   gotUnord;

  // Backpressure stream: operands, mode and hand-computed per-lane results.
  logic [63:0] bpA[5]        = '{64'h40000000_3F800000, 64'hBF800000_C0000000, 64'h3F800000_80000000,
                                 64'hC0000000_3F800000, 64'h40490FDB_7FC00000};
  logic [63:0] bpB[5]        = '{64'h3F800000_40000000, 64'hC0000000_BF800000, 64'h3F800001_00000000,
                                 64'hBF800000_40000000, 64'h40490FDB_3F800000};
  logic [2:0]  bpMode[5]     = '{3'd2, 3'd4, 3'd0, 3'd7, 3'd1};
  logic [1:0]  bpExpFlag[5]  = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01};
  logic [63:0] bpExpSel[5]   = '{64'h0, 64'h0, 64'h0, 64'hBF800000_40000000, 64'h0};
  logic [1:0]  bpExpUnord[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

  always #5 clk = ~clk;

  fp_cmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flag  (out_flag),
    .out_sel   (out_sel),
    .out_unord (out_unord)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one token into an idle pipeline, checks the two-cycle latency and captures the result.
  task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] mode);
    @(negedge clk);
    in_a     = {32'h0, a0};
    in_b     = {32'h0, b0};
    in_mode  = mode;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("latency_valid", 64'(out_valid), 64'd1);
    gotFlag  = out_flag;
    gotSel   = out_sel;
    gotUnord = out_unord;
  endtask

  initial begin
    int sent;
    int received;
    int stallLeft;
    bit seenFirst;
    bit holding;
    logic [LANES-1:0]   heldFlag;
    logic [LANES*W-1:0] heldSel;
    logic [LANES-1:0]   heldUnord;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_flag",  64'(out_flag),  64'd0);
    checkOutput("reset_out_sel",   64'(out_sel),   64'd0);
    checkOutput("reset_out_unord", 64'(out_unord), 64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;

    applyStimulus(32'h3F800000, 32'h40000000, 3'd2);
    checkOutput("lt_1_2", 64'(gotFlag[0]), 64'd1);
    checkOutput("lt_sel_zero", 64'(gotSel[31:0]), 64'd0);
    applyStimulus(32'h40000000, 32'h3F800000, 3'd2);
    checkOutput("lt_2_1", 64'(gotFlag[0]), 64'd0);
    applyStimulus(32'h40490FDB, 32'h40490FDB, 3'd5);
    checkOutput("ge_equal", 64'(gotFlag[0]), 64'd1);

    applyStimulus(32'hC0000000, 32'hBF800000, 3'd2);
    checkOutput("lt_neg", 64'(gotFlag[0]), 64'd1);
    applyStimulus(32'hC0000000, 32'hBF800000, 3'd4);
    checkOutput("gt_neg", 64'(gotFlag[0]), 64'd0);

    applyStimulus(32'h7F7FFFFF, 32'h7F800000, 3'd2);
    checkOutput("lt_maxfinite_inf", 64'(gotFlag[0]), 64'd1);
    applyStimulus(32'h00000001, 32'h00000002, 3'd3);
    checkOutput("le_subnormal", 64'(gotFlag[0]), 64'd1);

    applyStimulus(32'h80000000, 32'h00000000, 3'd0);
    checkOutput("eq_zeros", 64'(gotFlag[0]), 64'd1);
    applyStimulus(32'h80000000, 32'h00000000, 3'd2);
    checkOutput("lt_zeros", 64'(gotFlag[0]), 64'd0);
    applyStimulus(32'h80000000, 32'h00000000, 3'd6);
    checkOutput("min_nz_pz_sel",  64'(gotSel[31:0]), 64'h80000000);
    checkOutput("min_nz_pz_flag", 64'(gotFlag[0]),   64'd1);
    applyStimulus(32'h00000000, 32'h80000000, 3'd6);
    checkOutput("min_pz_nz_sel",  64'(gotSel[31:0]), 64'h80000000);
    checkOutput("min_pz_nz_flag", 64'(gotFlag[0]),   64'd0);
    applyStimulus(32'h80000000, 32'h00000000, 3'd7);
    checkOutput("max_nz_pz_sel",  64'(gotSel[31:0]), 64'h00000000);
    checkOutput("max_nz_pz_flag", 64'(gotFlag[0]),   64'd0);
    applyStimulus(32'h00000000, 32'h80000000, 3'd7);
    checkOutput("max_pz_nz_sel",  64'(gotSel[31:0]), 64'h00000000);
    checkOutput("max_pz_nz_flag", 64'(gotFlag[0]),   64'd1);

    applyStimulus(32'h7FC00000, 32'h3F800000, 3'd2);
    checkOutput("nan_lt",       64'(gotFlag[0]),  64'd0);
    checkOutput("nan_lt_unord", 64'(gotUnord[0]), 64'd1);
    applyStimulus(32'h7FC00000, 32'h3F800000, 3'd0);
    checkOutput("nan_eq", 64'(gotFlag[0]), 64'd0);
    applyStimulus(32'h7FC00000, 32'h3F800000, 3'd1);
    checkOutput("nan_ne",       64'(gotFlag[0]),  64'd1);
    checkOutput("nan_ne_unord", 64'(gotUnord[0]), 64'd1);
    applyStimulus(32'h7FC00000, 32'h3F800000, 3'd7);
    checkOutput("nan_max_sel",   64'(gotSel[31:0]), 64'h3F800000);
    checkOutput("nan_max_unord", 64'(gotUnord[0]),  64'd1);
    applyStimulus(32'hFFC00001, 32'h7F800001, 3'd6);
    checkOutput("nan2_min_sel",  64'(gotSel[31:0]), 64'h7FC00000);
    checkOutput("nan2_min_flag", 64'(gotFlag[0]),   64'd0);
    applyStimulus(32'h3F800000, 32'h40000000, 3'd1);
    checkOutput("ordered_unord", 64'(gotUnord[0]), 64'd0);

    // Backpressure: five back-to-back tokens, out_ready held low for three cycles at the first result.
    sent      = 0;
    received  = 0;
    stallLeft = 0;
    seenFirst = 1'b0;
    holding   = 1'b0;
    heldFlag  = '0;
    heldSel   = '0;
    heldUnord = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && received < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid && !seenFirst) begin
        seenFirst = 1'b1;
        stallLeft = 3;
      end
      if (stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = 1'b1;
      end
      if (sent < 5) begin
        in_a     = bpA[sent];
        in_b     = bpB[sent];
        in_mode  = bpMode[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid) begin
        if (holding) begin
          checkOutput("bp_hold_flag",  64'(out_flag),  64'(heldFlag));
          checkOutput("bp_hold_sel",   64'(out_sel),   64'(heldSel));
          checkOutput("bp_hold_unord", 64'(out_unord), 64'(heldUnord));
        end
        if (out_ready) begin
          checkOutput("bp_flag",  64'(out_flag),  64'(bpExpFlag[received]));
          checkOutput("bp_sel",   64'(out_sel),   bpExpSel[received]);
          checkOutput("bp_unord", 64'(out_unord), 64'(bpExpUnord[received]));
          received++;
          holding = 1'b0;
        end else begin
          heldFlag  = out_flag;
          heldSel   = out_sel;
          heldUnord = out_unord;
          holding   = 1'b1;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_sent",     64'(sent),     64'd5);
    checkOutput("bp_received", 64'(received), 64'd5);
    repeat (3) @(negedge clk);
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    // Mid-stream reset with one token at the output and one in stage 1.
    @(negedge clk);
    in_a     = {32'h40000000, 32'h3F800000};
    in_b     = {32'h3F800000, 32'h40000000};
    in_mode  = 3'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_a     = {32'h3F800000, 32'h40000000};
    in_b     = {32'h40000000, 32'h3F800000};
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_reset_in_ready",  64'(in_ready),  64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("no_stale_result", 64'(out_valid), 64'd0);
    end
    applyStimulus(32'h3F800000, 32'h40000000, 3'd2);
    checkOutput("post_reset_lt", 64'(gotFlag[0]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
